// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch stage: machine word, PC-mux select and fetch FSM states.
// Also holds the word-alignment helper used when taking a redirect.
package pc_fetch_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] rvga_word;

    typedef enum logic {
        pcmux_pc  = 1'b0,
        pcmux_jmp = 1'b1
    } pcmux_selop;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } fetch_state;

    // Redirect targets are forced onto a word boundary.
    function automatic rvga_word align_word(input rvga_word a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_obuf.sv
// One-entry valid/ready output register between fetch and decode.
// Flush beats load, load beats drain; payload is only written on a surviving load.
module fetch_obuf
    import pc_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  rvga_word i_load_pc,
    input  rvga_word i_load_instr,
    input  logic     i_flush,
    input  logic     i_ready,
    output logic     o_valid,
    output rvga_word o_pc,
    output rvga_word o_instr
);

    logic     r_valid;
    rvga_word r_pc;
    rvga_word r_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load && !i_flush) begin
                r_pc    <= i_load_pc;
                r_instr <= i_load_instr;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC owner: issues imem requests, applies execute-stage redirects and
// hands {pc, instr} to decode. imem: req held with stable addr until a one-cycle ack.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter rvga_word RESET_PC = 32'h0000_0000,
    parameter rvga_word PC_STEP  = 32'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  pcmux_selop pcmux_sel,
    input  rvga_word   jmp_tgt,
    output logic       imem_req,
    output rvga_word   imem_addr,
    input  logic       imem_ack,
    input  rvga_word   imem_rdata,
    output logic       if_valid,
    input  logic       if_ready,
    output rvga_word   if_pc,
    output rvga_word   if_instr,
    output logic       tgt_misalign,
    output fetch_state dbg_state
);

    fetch_state r_state;
    fetch_state w_next_state;
    rvga_word   r_pc;
    rvga_word   r_addr;
    logic       r_pend;
    logic       r_misalign;

    logic       w_redir;
    logic       w_can_issue;
    logic       w_req;
    rvga_word   w_addr;
    logic       w_load;
    logic       w_obuf_valid;

    assign w_redir     = (pcmux_sel == pcmux_jmp) && (r_state != S_IDLE);
    assign w_can_issue = !w_obuf_valid || if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: begin
                if (w_redir && r_pend && !imem_ack) begin
                    w_next_state = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A new request never starts in a redirect cycle; an outstanding one is never withdrawn.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        w_load = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req  = r_pend || (w_can_issue && !w_redir);
                w_load = w_req && imem_ack && !w_redir;
            end
            S_DROP: begin
                w_req  = 1'b1;
                w_addr = r_addr;
            end
            default: begin
                w_req  = 1'b0;
                w_addr = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_pend     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_addr     <= w_addr;
            r_misalign <= w_redir && jmp_tgt[1];
            r_pend     <= (r_state == S_FETCH) && w_req && !imem_ack && !w_redir;
            if (w_redir) begin
                r_pc <= align_word(jmp_tgt);
            end else if (w_load) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_obuf u_obuf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_pc    (w_addr),
        .i_load_instr (imem_rdata),
        .i_flush      (w_redir),
        .i_ready      (if_ready),
        .o_valid      (w_obuf_valid),
        .o_pc         (if_pc),
        .o_instr      (if_instr)
    );

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign if_valid     = w_obuf_valid;
    assign tgt_misalign = r_misalign;
    assign dbg_state    = r_state;

endmodule
